// File: rtl/bus_source_arbiter.sv
// Bus source arbiter: round-robin selection of the bus driver, producing a
// registered select code and a one-hot grant. The owner may keep the bus
// for a bounded number of extra cycles while it holds lock.
module bus_source_arbiter #(
    parameter int N_SRC    = 24,
    parameter int SEL_W    = 5,
    parameter int MAX_HOLD = 15
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N_SRC-1:0] src_req,
    input  logic             lock,
    output logic [SEL_W-1:0] Select,
    output logic [N_SRC-1:0] grant,
    output logic             bus_valid,
    output logic             contention,
    output logic             hold_timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } stateT;

    stateT            state, stateNext;
    logic [SEL_W-1:0] ptr, ptrNext;
    logic [SEL_W-1:0] owner, ownerNext;
    logic [CNT_W-1:0] holdCnt, holdCntNext;
    logic [SEL_W-1:0] selectNext;
    logic [N_SRC-1:0] grantNext;
    logic             busValidNext;
    logic             contentionNext;
    logic             timeoutNext;

    logic [SEL_W-1:0] releasePtr;
    logic [N_SRC-1:0] ownerMask;
    logic [N_SRC-1:0] arbReq;
    logic [SEL_W-1:0] arbPtr;
    logic             arbFound;
    logic [SEL_W-1:0] arbWinner;
    logic             multiReq;
    logic             doRelease;

    // Pick the request set and start point for this edge: all requests from
    // the stored pointer when idle, otherwise everyone but the current owner
    // starting just past the owner (used only when the owner releases).
    always_comb begin
        releasePtr = (owner == SEL_W'(N_SRC - 1)) ? '0 : owner + SEL_W'(1);
        ownerMask  = {{(N_SRC-1){1'b0}}, 1'b1} << owner;
        multiReq   = (src_req & (src_req - N_SRC'(1))) != '0;
        if (state == IDLE) begin
            arbReq = src_req;
            arbPtr = ptr;
        end else begin
            arbReq = src_req & ~ownerMask;
            arbPtr = releasePtr;
        end
    end

    // Round-robin search: first set request at arbPtr, arbPtr+1, ... wrapping
    // at N_SRC-1 so unused select codes can never be produced.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idxSel;
        arbFound  = 1'b0;
        arbWinner = '0;
        idx       = 0;
        idxSel    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(arbPtr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            idxSel = SEL_W'(idx);
            if (!arbFound && arbReq[idxSel]) begin
                arbFound  = 1'b1;
                arbWinner = idxSel;
            end
        end
    end

    // Next-state logic: grant from idle, promote to hold under lock, and on
    // release hand the bus straight to the next requester when there is one.
    always_comb begin
        stateNext      = state;
        ptrNext        = ptr;
        ownerNext      = owner;
        holdCntNext    = holdCnt;
        selectNext     = Select;
        grantNext      = grant;
        busValidNext   = bus_valid;
        contentionNext = 1'b0;
        timeoutNext    = 1'b0;
        doRelease      = 1'b0;

        case (state)
            IDLE: begin
                if (arbFound) begin
                    stateNext      = GRANT;
                    ownerNext      = arbWinner;
                    selectNext     = arbWinner;
                    grantNext      = {{(N_SRC-1){1'b0}}, 1'b1} << arbWinner;
                    busValidNext   = 1'b1;
                    contentionNext = multiReq;
                    holdCntNext    = '0;
                end
            end
            GRANT: begin
                if (lock && src_req[owner]) begin
                    stateNext   = HOLD;
                    holdCntNext = CNT_W'(1);
                end else begin
                    doRelease = 1'b1;
                end
            end
            HOLD: begin
                if (!lock || !src_req[owner]) begin
                    doRelease = 1'b1;
                end else if (holdCnt == CNT_W'(MAX_HOLD)) begin
                    doRelease   = 1'b1;
                    timeoutNext = 1'b1;
                end else begin
                    holdCntNext = holdCnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (doRelease) begin
            ptrNext     = releasePtr;
            holdCntNext = '0;
            if (arbFound) begin
                stateNext      = GRANT;
                ownerNext      = arbWinner;
                selectNext     = arbWinner;
                grantNext      = {{(N_SRC-1){1'b0}}, 1'b1} << arbWinner;
                busValidNext   = 1'b1;
                contentionNext = multiReq;
            end else begin
                stateNext    = IDLE;
                grantNext    = '0;
                busValidNext = 1'b0;
            end
        end
    end

    // State and output registers; clear drops ownership immediately.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            holdCnt      <= '0;
            Select       <= '0;
            grant        <= '0;
            bus_valid    <= 1'b0;
            contention   <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= stateNext;
            ptr          <= ptrNext;
            owner        <= ownerNext;
            holdCnt      <= holdCntNext;
            Select       <= selectNext;
            grant        <= grantNext;
            bus_valid    <= busValidNext;
            contention   <= contentionNext;
            hold_timeout <= timeoutNext;
        end
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed testbench for bus_source_arbiter: one instance with the default
// hold limit and one with a short limit for the forced-release scenario.
module tb_bus_source_arbiter;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] req   = '0;
    logic        lock  = 1'b0;
    logic [4:0]  sel;
    logic [23:0] gnt;
    logic        bv, cont, hto;

    logic [23:0] reqT  = '0;
    logic        lockT = 1'b0;
    logic [4:0]  selT;
    logic [23:0] gntT;
    logic        bvT, contT, htoT;

    int testsRun    = 0;
    int testsFailed = 0;

    bus_source_arbiter dut (
        .clock(clock), .clear(clear), .src_req(req), .lock(lock),
        .Select(sel), .grant(gnt), .bus_valid(bv),
        .contention(cont), .hold_timeout(hto)
    );

    bus_source_arbiter #(.N_SRC(24), .SEL_W(5), .MAX_HOLD(3)) dutT (
        .clock(clock), .clear(clear), .src_req(reqT), .lock(lockT),
        .Select(selT), .grant(gntT), .bus_valid(bvT),
        .contention(contT), .hold_timeout(htoT)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic applyReset();
        @(negedge clock);
        clear = 1'b1;
        req   = '0;
        lock  = 1'b0;
        reqT  = '0;
        lockT = 1'b0;
        #2;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        req = 24'd1 << 9;
        @(negedge clock);
        clear = 1'b1;
        #1;
        testsRun++;
        if (sel !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_sel got %0d want 0", sel); end
        testsRun++;
        if (gnt !== 24'd0) begin testsFailed++; $display("[TB] FAIL reset_grant got %h want 0", gnt); end
        testsRun++;
        if ({bv, cont, hto} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags got %b want 000", {bv, cont, hto}); end
        testsRun++;
        if ({bvT, htoT, gntT} !== 26'd0) begin testsFailed++; $display("[TB] FAIL reset_short got %b want 0", {bvT, htoT, gntT}); end
        req   = '0;
        clear = 1'b0;
    endtask

    task automatic test_single_and_wrap();
        applyReset();
        req = 24'd1 << 21;
        @(negedge clock);
        testsRun++;
        if (sel !== 5'd21) begin testsFailed++; $display("[TB] FAIL single_sel got %0d want 21", sel); end
        testsRun++;
        if (gnt !== (24'd1 << 21)) begin testsFailed++; $display("[TB] FAIL single_grant got %h want %h", gnt, 24'd1 << 21); end
        testsRun++;
        if ({bv, cont} !== 2'b10) begin testsFailed++; $display("[TB] FAIL single_flags got %b want 10", {bv, cont}); end
        req = '0;
        @(negedge clock);
        testsRun++;
        if ({bv, sel, gnt} !== {1'b0, 5'd21, 24'd0}) begin testsFailed++; $display("[TB] FAIL single_release got bv=%b sel=%0d gnt=%h want bv=0 sel=21 gnt=0", bv, sel, gnt); end
        // Pointer now 22: with bits 0 and 22 requesting, 22 must win.
        req = (24'd1 << 22) | 24'd1;
        @(negedge clock);
        testsRun++;
        if (sel !== 5'd22) begin testsFailed++; $display("[TB] FAIL ptr22_sel got %0d want 22", sel); end
        req = (24'd1 << 23) | 24'd1;
        @(negedge clock);
        testsRun++;
        if ({sel, bv, cont} !== {5'd23, 1'b1, 1'b1}) begin testsFailed++; $display("[TB] FAIL wrap23 got sel=%0d bv=%b cont=%b want sel=23 bv=1 cont=1", sel, bv, cont); end
        @(negedge clock);
        testsRun++;
        if ({sel, gnt, bv} !== {5'd0, 24'd1, 1'b1}) begin testsFailed++; $display("[TB] FAIL wrap0 got sel=%0d gnt=%h bv=%b want sel=0 gnt=000001 bv=1", sel, gnt, bv); end
        req = '0;
        @(negedge clock);
        testsRun++;
        if ({bv, gnt} !== 25'd0) begin testsFailed++; $display("[TB] FAIL wrap_idle got bv=%b gnt=%h want 0", bv, gnt); end
    endtask

    task automatic test_round_robin();
        int expSeq [6];
        expSeq = '{3, 16, 20, 3, 16, 20};
        applyReset();
        req = (24'd1 << 3) | (24'd1 << 16) | (24'd1 << 20);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            testsRun++;
            if (sel !== 5'(expSeq[i])) begin testsFailed++; $display("[TB] FAIL rr_sel[%0d] got %0d want %0d", i, sel, expSeq[i]); end
            testsRun++;
            if (gnt !== (24'd1 << expSeq[i])) begin testsFailed++; $display("[TB] FAIL rr_grant[%0d] got %h want %h", i, gnt, 24'd1 << expSeq[i]); end
            testsRun++;
            if ({bv, cont} !== 2'b11) begin testsFailed++; $display("[TB] FAIL rr_flags[%0d] got %b want 11", i, {bv, cont}); end
        end
        req = '0;
        @(negedge clock);
        testsRun++;
        if (bv !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_idle got %b want 0", bv); end
    endtask

    task automatic test_lock_hold();
        applyReset();
        req  = 24'd1 << 19;
        lock = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            testsRun++;
            if ({sel, bv, gnt} !== {5'd19, 1'b1, 24'd1 << 19}) begin testsFailed++; $display("[TB] FAIL hold_cycle[%0d] got sel=%0d bv=%b gnt=%h want sel=19 bv=1", i, sel, bv, gnt); end
            if (i == 1) begin
                testsRun++;
                if (cont !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_cont got %b want 0", cont); end
                req = req | (24'd1 << 5);
            end
            if (i == 6) begin
                lock = 1'b0;
            end
        end
        @(negedge clock);
        testsRun++;
        if ({sel, bv, cont, hto} !== {5'd5, 1'b1, 1'b1, 1'b0}) begin testsFailed++; $display("[TB] FAIL hold_handoff got sel=%0d bv=%b cont=%b hto=%b want sel=5 bv=1 cont=1 hto=0", sel, bv, cont, hto); end
        req = '0;
        @(negedge clock);
        testsRun++;
        if (bv !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_idle got %b want 0", bv); end
    endtask

    task automatic test_timeout();
        applyReset();
        reqT  = 24'd1 << 7;
        lockT = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            testsRun++;
            if ({selT, bvT, htoT} !== {5'd7, 1'b1, 1'b0}) begin testsFailed++; $display("[TB] FAIL to_own[%0d] got sel=%0d bv=%b hto=%b want sel=7 bv=1 hto=0", i, selT, bvT, htoT); end
        end
        @(negedge clock);
        testsRun++;
        if ({bvT, htoT, gntT} !== {1'b0, 1'b1, 24'd0}) begin testsFailed++; $display("[TB] FAIL to_alone got bv=%b hto=%b gnt=%h want bv=0 hto=1 gnt=0", bvT, htoT, gntT); end
        @(negedge clock);
        testsRun++;
        if ({selT, bvT, htoT} !== {5'd7, 1'b1, 1'b0}) begin testsFailed++; $display("[TB] FAIL to_regrant got sel=%0d bv=%b hto=%b want sel=7 bv=1 hto=0", selT, bvT, htoT); end
        reqT = reqT | (24'd1 << 2);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            testsRun++;
            if ({selT, htoT} !== {5'd7, 1'b0}) begin testsFailed++; $display("[TB] FAIL to_hold2[%0d] got sel=%0d hto=%b want sel=7 hto=0", i, selT, htoT); end
        end
        @(negedge clock);
        testsRun++;
        if ({selT, bvT, htoT, contT} !== {5'd2, 1'b1, 1'b1, 1'b1}) begin testsFailed++; $display("[TB] FAIL to_handoff got sel=%0d bv=%b hto=%b cont=%b want sel=2 bv=1 hto=1 cont=1", selT, bvT, htoT, contT); end
        reqT = 24'd1 << 7;
        @(negedge clock);
        testsRun++;
        if ({selT, bvT, htoT} !== {5'd7, 1'b1, 1'b0}) begin testsFailed++; $display("[TB] FAIL to_after_other got sel=%0d bv=%b hto=%b want sel=7 bv=1 hto=0", selT, bvT, htoT); end
        reqT  = '0;
        lockT = 1'b0;
    endtask

    task automatic test_async_reset();
        applyReset();
        req  = 24'd1 << 12;
        lock = 1'b1;
        @(negedge clock);
        @(negedge clock);
        testsRun++;
        if ({sel, bv} !== {5'd12, 1'b1}) begin testsFailed++; $display("[TB] FAIL async_pre got sel=%0d bv=%b want sel=12 bv=1", sel, bv); end
        #2;
        clear = 1'b1;
        #1;
        testsRun++;
        if ({sel, bv, gnt} !== {5'd0, 1'b0, 24'd0}) begin testsFailed++; $display("[TB] FAIL async_drop got sel=%0d bv=%b gnt=%h want all 0", sel, bv, gnt); end
        @(negedge clock);
        clear = 1'b0;
        lock  = 1'b0;
        req   = (24'd1 << 12) | (24'd1 << 2);
        @(negedge clock);
        testsRun++;
        if ({sel, bv, cont} !== {5'd2, 1'b1, 1'b1}) begin testsFailed++; $display("[TB] FAIL async_after got sel=%0d bv=%b cont=%b want sel=2 bv=1 cont=1", sel, bv, cont); end
        req = '0;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_single_and_wrap();
        test_round_robin();
        test_lock_hold();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Sits on the source side of the 32-bit datapath bus and generates the 5-bit source-select code that the bus multiplexer consumes.
- Each potential driver raises a request bit; the source-select code numbering is R0–R15 = 0–15, HI = 16, LO = 17, ZHi = 18, ZLo = 19, PC = 20, MDR = 21, InPort = 22, C-sign-extended = 23.
- The block arbitrates between requesters round-robin and issues a registered select code plus a one-hot grant.
- The grant can be held across multiple cycles under a bounded lock.

Parameters:
- N_SRC, 24: number of bus sources; request index equals the select code.
- SEL_W, 5: width of the select code; requires 2^SEL_W >= N_SRC.
- MAX_HOLD, 15: maximum number of consecutive locked cycles after the initial grant cycle; must be >= 1.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- src_req  in  N_SRC  request per source; bit i requests select code i.
- lock  in  1  asks the current owner to keep the bus beyond one cycle.
- Select  out  SEL_W  registered select code to the bus multiplexer.
- grant  out  N_SRC  registered one-hot grant; all zero when no owner.
- bus_valid  out  1  high while Select designates a granted owner.
- contention  out  1  one-cycle pulse: more than one request was present at an arbitration that produced a grant.
- hold_timeout  out  1  one-cycle pulse: a lock was forcibly ended by MAX_HOLD.

Behaviour:

Reset (clear = 1, asynchronous):
- Select = 0, grant = 0, bus_valid = 0, contention = 0, hold_timeout = 0.
- State = IDLE, round-robin pointer ptr = 0, hold counter = 0.
- Reset asserted mid-grant drops ownership immediately; there is no completion of the transfer.

States:
- IDLE: no owner.
  - If src_req != 0 at a clock edge, the winner w is the first set bit searching ptr, ptr+1, …, N_SRC-1, 0, …, ptr-1.
  - At that edge: grant = one-hot(w), Select = w, bus_valid = 1, state becomes GRANT.
  - Latency is one cycle from request to select.
- GRANT: the first owned cycle. At the next edge:
  - if lock = 1 and src_req[w] = 1, go to HOLD with counter = 1;
  - otherwise release.
- HOLD: grant, Select and bus_valid are unchanged. At each edge:
  - if lock = 0 or src_req[w] = 0, release;
  - else if counter == MAX_HOLD, release and pulse hold_timeout;
  - else counter + 1.
- Release:
  - ptr = (w + 1) mod N_SRC, wrapping at N_SRC-1 to 0, never into unused codes 24–31.
  - If any src_req bit is set other than w at the release edge, re-arbitrate in the same edge using the new ptr. The new winner is granted with no idle cycle (back-to-back GRANT) and bus_valid stays high.
  - w is excluded from this same-edge re-arbitration even if it is still requesting.
  - Otherwise go to IDLE with grant = 0 and bus_valid = 0; Select holds its last value.

Pulses:
- contention is registered at the granting edge and is high for exactly the GRANT cycle when popcount(src_req) >= 2 at that edge; it is low otherwise.
- hold_timeout is high for exactly one cycle following the forced release edge.

Boundary conditions:
- Requests are sampled only at arbitration edges; a request that rises and falls between them is lost.
- src_req bits at index >= N_SRC do not exist; Select never exceeds N_SRC-1.
- lock while in IDLE is ignored. lock in GRANT with the owner's request low means release.
- Invariant: grant is always zero or one-hot, and Select equals the index of the set bit whenever bus_valid = 1.

Test Plan:
- Reset then single request: src_req bit 21 (MDR) held for 1 cycle, lock = 0 → next cycle Select = 21, grant = 1<<21, bus_valid = 1, contention = 0; following cycle bus_valid = 0, Select stays 21, ptr = 22.
- Round-robin fairness: after reset, assert bits 3, 16 and 20 continuously with lock = 0 → grants in order 3, 16, 20, 3, 16, 20 on consecutive cycles with no idle gaps; contention = 1 on every grant cycle.
- Wrap-around: ptr = 23 (after a grant of 22), requests on bits 0 and 23 → 23 is granted, then 0; pointer wraps to 0 and codes 24–31 never appear.
- Lock hold: bit 19 (ZLo) requested with lock = 1 for 5 cycles, then lock = 0, while bit 5 also requests → Select = 19 for 6 cycles (GRANT plus 5 HOLD), then Select = 5 on the next cycle with bus_valid continuously 1.
- Timeout: MAX_HOLD = 3, bit 7 requests with lock = 1 indefinitely → grant of 7 lasts 4 cycles, hold_timeout pulses once, and 7 is re-granted only after the other requesters when they are present, or immediately from IDLE when alone.
- Async reset mid-HOLD: assert clear between clock edges while Select = 12 and bus_valid = 1 → outputs go to 0 immediately without a clock edge; after clear deasserts, requests on bits 12 and 2 → bit 2 is granted first (ptr = 0).
